// File: rtl/intersection_pkg.sv
// +----------------------------------------------------------------------------+
// | Package  : intersection_pkg                                                |
// | Purpose  : Shared phase encoding, lamp encodings, default phase durations  |
// |            and lamp-decode helpers for the intersection sequencer.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package intersection_pkg;

  // Phase encoding, in cyclic order of the sequence.
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    AR_NS     = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    AR_EW     = 3'd5
  } phase_e;

  // Lamp encodings, bit order {red, yellow, green}.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // Default durations in cycles.
  localparam int DEF_GREEN_T  = 60;
  localparam int DEF_YELLOW_T = 5;
  localparam int DEF_ALLRED_T = 2;
  localparam int DEF_PED_MIN  = 10;
  localparam int DEF_CNT_W    = 8;

  function automatic logic [2:0] ns_lamp_of(input phase_e p);
    case (p)
      NS_GREEN:  return LAMP_GREEN;
      NS_YELLOW: return LAMP_YELLOW;
      default:   return LAMP_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp_of(input phase_e p);
    case (p)
      EW_GREEN:  return LAMP_GREEN;
      EW_YELLOW: return LAMP_YELLOW;
      default:   return LAMP_RED;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/phase_timer.sv
// +----------------------------------------------------------------------------+
// | Module   : phase_timer                                                     |
// | Purpose  : Phase countdown counter. Loads a duration, counts down by one   |
// |            per enabled cycle, holds while frozen, and saturates at 1.      |
// | Ports    : clk, rst_n      - clock, async active-low reset                 |
// |            load, load_val  - load a new count (takes priority)             |
// |            dec             - decrement enable                              |
// |            freeze          - hold the current count                        |
// |            count           - current count                                 |
// |            done            - high when count == 1 (last cycle of phase)    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module phase_timer #(
  parameter int CNT_W     = 8,
  parameter int RESET_VAL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             freeze,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= CNT_W'(RESET_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (dec && !freeze && (count > ONE)) begin
      // Saturate at 1 so the count can never wrap through zero.
      count <= count - ONE;
    end
  end

  assign done = (count == ONE);

endmodule

`default_nettype wire

// File: rtl/intersection_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module   : intersection_sequencer                                          |
// | Purpose  : Two-direction traffic light sequencer with pedestrian green     |
// |            shortening and optional emergency pre-emption.                  |
// | Ports    : clk, rst_n          - clock, async active-low reset             |
// |            ped_req[1:0]        - [0] shorten NS green, [1] shorten EW green |
// |            ns_lamp, ew_lamp    - {red,yellow,green}, one-hot, registered   |
// |            walk_ns, walk_ew    - walk indications, registered              |
// |            remaining           - cycles left in the current phase          |
// |            phase               - current phase encoding                    |
// |            emerg_req/emerg_dir - only with EMERGENCY_PREEMPT_EN defined    |
// | Config   : EMERGENCY_PREEMPT_EN adds emergency pre-emption inputs.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module intersection_sequencer
  import intersection_pkg::*;
#(
  parameter int GREEN_T  = DEF_GREEN_T,
  parameter int YELLOW_T = DEF_YELLOW_T,
  parameter int ALLRED_T = DEF_ALLRED_T,
  parameter int PED_MIN  = DEF_PED_MIN,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ped_req,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic             emerg_req,
  input  logic             emerg_dir,
`endif
  output logic [2:0]       ns_lamp,
  output logic [2:0]       ew_lamp,
  output logic             walk_ns,
  output logic             walk_ew,
  output logic [CNT_W-1:0] remaining,
  output logic [2:0]       phase
);

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_MIN);
  // Green length when entered with a pending pedestrian request.
  localparam logic [CNT_W-1:0] SHORT_LD  = (GREEN_T < PED_MIN) ? GREEN_LD : PED_LD;

  phase_e           state, nxt_state;
  logic [1:0]       pending, nxt_pending;
  logic             tmr_load, tmr_freeze, tmr_done;
  logic [CNT_W-1:0] tmr_load_val;

  phase_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (ALLRED_T)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (1'b1),
    .freeze   (tmr_freeze),
    .count    (remaining),
    .done     (tmr_done)
  );

  always_comb begin
    nxt_state    = state;
    nxt_pending  = pending;
    tmr_load     = 1'b0;
    tmr_load_val = remaining;
    tmr_freeze   = 1'b0;

    // Requests arriving outside their own green are remembered for it.
    if (state != NS_GREEN) nxt_pending[0] = pending[0] | ped_req[0];
    if (state != EW_GREEN) nxt_pending[1] = pending[1] | ped_req[1];

    case (state)
      NS_GREEN: begin
        if (tmr_done) begin
          // Transition wins over a last-cycle request; defer it instead.
          nxt_state      = NS_YELLOW;
          tmr_load       = 1'b1;
          tmr_load_val   = YELLOW_LD;
          nxt_pending[0] = pending[0] | ped_req[0];
        end else if (ped_req[0] && (remaining > PED_LD)) begin
          tmr_load     = 1'b1;
          tmr_load_val = PED_LD;
        end
      end
      NS_YELLOW: begin
        if (tmr_done) begin
          nxt_state    = AR_NS;
          tmr_load     = 1'b1;
          tmr_load_val = ALLRED_LD;
        end
      end
      AR_NS: begin
        if (tmr_done) begin
          nxt_state      = EW_GREEN;
          tmr_load       = 1'b1;
          tmr_load_val   = nxt_pending[1] ? SHORT_LD : GREEN_LD;
          nxt_pending[1] = 1'b0;
        end
      end
      EW_GREEN: begin
        if (tmr_done) begin
          nxt_state      = EW_YELLOW;
          tmr_load       = 1'b1;
          tmr_load_val   = YELLOW_LD;
          nxt_pending[1] = pending[1] | ped_req[1];
        end else if (ped_req[1] && (remaining > PED_LD)) begin
          tmr_load     = 1'b1;
          tmr_load_val = PED_LD;
        end
      end
      EW_YELLOW: begin
        if (tmr_done) begin
          nxt_state    = AR_EW;
          tmr_load     = 1'b1;
          tmr_load_val = ALLRED_LD;
        end
      end
      AR_EW: begin
        if (tmr_done) begin
          nxt_state      = NS_GREEN;
          tmr_load       = 1'b1;
          tmr_load_val   = nxt_pending[0] ? SHORT_LD : GREEN_LD;
          nxt_pending[0] = 1'b0;
        end
      end
      default: begin
        // Unreachable encodings recover through the all-red clearance.
        nxt_state    = AR_EW;
        tmr_load     = 1'b1;
        tmr_load_val = ALLRED_LD;
      end
    endcase

`ifdef EMERGENCY_PREEMPT_EN
    if (emerg_req) begin
      if (state == (emerg_dir ? NS_GREEN : EW_GREEN)) begin
        // Opposing green is cut straight to its yellow.
        nxt_state    = emerg_dir ? NS_YELLOW : EW_YELLOW;
        tmr_load     = 1'b1;
        tmr_load_val = YELLOW_LD;
      end else if (state == (emerg_dir ? EW_GREEN : NS_GREEN)) begin
        // Requested green holds with its count frozen.
        nxt_state              = state;
        tmr_load               = 1'b0;
        tmr_load_val           = remaining;
        tmr_freeze             = 1'b1;
        nxt_pending[emerg_dir] = pending[emerg_dir];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= AR_EW;
      pending <= 2'b00;
      ns_lamp <= LAMP_RED;
      ew_lamp <= LAMP_RED;
      walk_ns <= 1'b0;
      walk_ew <= 1'b0;
    end else begin
      state   <= nxt_state;
      pending <= nxt_pending;
      // Decoded from the next state so lamps change with the state register.
      ns_lamp <= ns_lamp_of(nxt_state);
      ew_lamp <= ew_lamp_of(nxt_state);
      walk_ns <= (nxt_state == NS_GREEN);
      walk_ew <= (nxt_state == EW_GREEN);
    end
  end

  assign phase = state;

endmodule

`default_nettype wire

// File: tb/tb_intersection_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_intersection_sequencer                                       |
// | Purpose  : Self-checking bench for intersection_sequencer against a        |
// |            phase-table reference model; directed and random ped requests.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_intersection_sequencer;
  import intersection_pkg::*;

  localparam int G  = 60;
  localparam int Y  = 5;
  localparam int AR = 2;
  localparam int P  = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ped_req;
  logic [2:0] ns_lamp, ew_lamp, phase;
  logic       walk_ns, walk_ew;
  logic [7:0] remaining;
`ifdef EMERGENCY_PREEMPT_EN
  logic       emerg_req = 1'b0;
  logic       emerg_dir = 1'b0;
`endif

  intersection_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ped_req   (ped_req),
`ifdef EMERGENCY_PREEMPT_EN
    .emerg_req (emerg_req),
    .emerg_dir (emerg_dir),
`endif
    .ns_lamp   (ns_lamp),
    .ew_lamp   (ew_lamp),
    .walk_ns   (walk_ns),
    .walk_ew   (walk_ew),
    .remaining (remaining),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase index 0..5 in cyclic order, cycles left, pending flags.
  int m_ph;
  int m_rem;
  bit m_pend [2];

  function automatic int dur(input int ph);
    case (ph)
      0, 3:    return G;
      1, 4:    return Y;
      default: return AR;
    endcase
  endfunction

  function automatic logic [2:0] ph_code(input int ph);
    case (ph)
      0:       return NS_GREEN;
      1:       return NS_YELLOW;
      2:       return AR_NS;
      3:       return EW_GREEN;
      4:       return EW_YELLOW;
      default: return AR_EW;
    endcase
  endfunction

  task automatic model_reset();
    m_ph      = 5;
    m_rem     = AR;
    m_pend[0] = 1'b0;
    m_pend[1] = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] p);
    int own;
    own = (m_ph == 0) ? 0 : (m_ph == 3) ? 1 : -1;
    for (int i = 0; i < 2; i++)
      if (own != i && p[i]) m_pend[i] = 1'b1;
    if (m_rem == 1) begin
      if (own >= 0 && p[own]) m_pend[own] = 1'b1;
      m_ph = (m_ph + 1) % 6;
      if (m_ph == 0 || m_ph == 3) begin
        if (m_pend[m_ph/3]) m_rem = (G < P) ? G : P;
        else                m_rem = G;
        m_pend[m_ph/3] = 1'b0;
      end else begin
        m_rem = dur(m_ph);
      end
    end else if (own >= 0 && p[own] && m_rem > P) begin
      m_rem = P;
    end else begin
      m_rem = m_rem - 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [2:0] ens, eew;
    ens = (m_ph == 0) ? 3'b001 : (m_ph == 1) ? 3'b010 : 3'b100;
    eew = (m_ph == 3) ? 3'b001 : (m_ph == 4) ? 3'b010 : 3'b100;
    chk("phase",     {29'd0, phase}, {29'd0, ph_code(m_ph)});
    chk("remaining", {24'd0, remaining}, m_rem);
    chk("ns_lamp",   {29'd0, ns_lamp}, {29'd0, ens});
    chk("ew_lamp",   {29'd0, ew_lamp}, {29'd0, eew});
    chk("walk_ns",   {31'd0, walk_ns}, {31'd0, (m_ph == 0)});
    chk("walk_ew",   {31'd0, walk_ew}, {31'd0, (m_ph == 3)});
  endtask

  // Drive one cycle of ped_req, advance the model, compare at the next negedge.
  task automatic step(input logic [1:0] p);
    ped_req = p;
    model_step(p);
    @(negedge clk);
    check_all();
    ped_req = 2'b00;
  endtask

  // Idle until the model reaches phase ph (and count rem, if rem >= 0).
  task automatic run_until(input string tag, input int ph, input int rem);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (m_ph == ph && (rem < 0 || m_rem == rem)) begin
        found = 1'b1;
        break;
      end
      step(2'b00);
    end
    if (!found) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=timeout expected=phase %0d", tag, ph);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    ped_req = 2'b00;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Undisturbed cycle, then cap at remaining=40.
    run_until("reach_ns40", 0, 40);
    step(2'b01);
    chk("ped_cap_40", {24'd0, remaining}, 10);
    run_until("reach_nsy", 1, -1);
    chk("yellow_after_cap", {29'd0, phase}, {29'd0, NS_YELLOW});

    // Request at remaining=7 has no effect beyond the normal decrement.
    run_until("reach_ns7", 0, 7);
    step(2'b01);
    chk("ped_no_cap_7", {24'd0, remaining}, 6);

    // Request during EW green shortens the next NS green only.
    run_until("reach_ewg", 3, -1);
    step(2'b01);
    run_until("reach_ns_short", 0, -1);
    chk("ns_short_load", {24'd0, remaining}, 10);
    run_until("leave_ns", 1, -1);
    run_until("reach_ns_full", 0, -1);
    chk("ns_full_load", {24'd0, remaining}, 60);

    // Last-cycle EW request: transition on schedule, next EW green short.
    run_until("reach_ew1", 3, 1);
    step(2'b10);
    chk("ew_last_transition", {29'd0, phase}, {29'd0, EW_YELLOW});
    run_until("reach_ew_short", 3, -1);
    chk("ew_short_load", {24'd0, remaining}, 10);

    // Asynchronous reset in EW yellow discards a pending NS request.
    run_until("reach_ewg2", 4, -1);
    run_until("reach_ewg3", 3, -1);
    step(2'b01);
    run_until("reach_ewy", 4, -1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_ns_lamp", {29'd0, ns_lamp}, 32'h4);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    run_until("reach_ns_after_rst", 0, -1);
    chk("post_reset_green", {24'd0, remaining}, 60);

    // Random pedestrian traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [1:0] p;
      p[0] = ($urandom_range(0, 19) == 0);
      p[1] = ($urandom_range(0, 19) == 0);
      step(p);
      chk("ns_onehot", {31'd0, $onehot(ns_lamp)}, 32'd1);
      chk("ew_onehot", {31'd0, $onehot(ew_lamp)}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/intersection_sequencer.md
INTERSECTION_SEQUENCER -- requirements
Module: intersection_sequencer

Interface
REQ-001 Parameter GREEN_T, default 60, green phase length in cycles.
REQ-002 Parameter YELLOW_T, default 5, yellow phase length in cycles.
REQ-003 Parameter ALLRED_T, default 2, all-red clearance length in cycles.
REQ-004 Parameter PED_MIN, default 10, remaining-green cap applied on a pedestrian request.
REQ-005 Parameter CNT_W, default 8, counter width; all durations SHALL be at least 1 and at most 2**CNT_W-1.
REQ-006 Port clk  input  1  clock, rising edge.
REQ-007 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 Port ped_req  input  2  [0] requests shortening of NS green; [1] requests shortening of EW green; level-sampled every cycle.
REQ-009 Port ns_lamp  output  3  NS lamps {red,yellow,green}, exactly one bit high.
REQ-010 Port ew_lamp  output  3  EW lamps {red,yellow,green}, exactly one bit high.
REQ-011 Port walk_ns  output  1  pedestrian walk along NS; high only in NS_GREEN.
REQ-012 Port walk_ew  output  1  pedestrian walk along EW; high only in EW_GREEN.
REQ-013 Port remaining  output  CNT_W  cycles left in the current phase, including the current cycle.
REQ-014 Port phase  output  3  current state encoding from the shared package.

Function
REQ-015 States: NS_GREEN, NS_YELLOW, AR_NS (all-red after NS), EW_GREEN, EW_YELLOW, AR_EW (all-red after EW); cyclic order NS_GREEN, NS_YELLOW, AR_NS, EW_GREEN, EW_YELLOW, AR_EW, NS_GREEN.
REQ-016 On phase entry, remaining loads that phase's duration; it decrements by 1 each cycle; when remaining==1 the next cycle enters the next state with a fresh load; a phase therefore lasts exactly its duration in cycles.
REQ-017 Lamp, walk and phase outputs are registered and change in the same cycle as the state; the green direction shows green or yellow, the other direction shows red; both show red in AR states.
REQ-018 ped_req[0] sampled high in NS_GREEN with remaining>PED_MIN: next remaining = PED_MIN; with remaining<=PED_MIN: normal decrement; ped_req[1] behaves the same in EW_GREEN.
REQ-019 ped_req[i] sampled high outside its own green sets pending[i]; on entry to that green, load min(GREEN_T, PED_MIN) and clear pending[i].
REQ-020 ped_req[i] high on the cycle where its green has remaining==1: the transition wins and the request is latched into pending[i] for the next occurrence of that green.
REQ-021 A request is consumed once; holding ped_req high across a phase has the same effect as a single pulse.
REQ-022 remaining never wraps: it never loads 0 and never decrements below 1.

Reset
REQ-023 While rst_n is low: state AR_EW, remaining=ALLRED_T, ns_lamp=ew_lamp=3'b100, walk_ns=walk_ew=0, pending=0; the first green after reset is NS_GREEN after ALLRED_T cycles.
REQ-024 Reset asserted mid-phase aborts the phase immediately, asynchronously, and discards pending requests.

Configuration
REQ-025 Macro EMERGENCY_PREEMPT_EN: when defined, adds inputs emerg_req (1 bit) and emerg_dir (1 bit, 0=NS, 1=EW).
REQ-026 With the macro and emerg_req high: if the opposite direction is green, it moves to its yellow on the next cycle; sequencing then runs to the requested direction's green, which holds (remaining frozen) while emerg_req is high; on release, normal decrement resumes.
REQ-027 Without the macro these ports do not exist and the sequencing is exactly REQ-015 to REQ-022.

Structure
REQ-028 Package intersection_pkg holds the phase enum, the lamp encodings and the default duration constants.
REQ-029 Sub-module phase_timer (load, load value, decrement, freeze, CNT_W-wide counter, done flag when the count is 1) implements the counter; the FSM, request latches and output decode stay in the top level.

Verification
REQ-030 Reset release, no requests -> AR_EW 2 cycles, NS_GREEN 60, NS_YELLOW 5, AR_NS 2, EW_GREEN 60; lamps one-hot throughout.
REQ-031 ped_req[0] pulsed at NS_GREEN remaining=40 -> next remaining=10, and NS_YELLOW starts 10 cycles later.
REQ-032 ped_req[0] pulsed at NS_GREEN remaining=7 -> no change; pulsed in EW_GREEN -> the next NS_GREEN lasts 10 cycles, and the one after lasts 60.
REQ-033 ped_req[1] high on the EW_GREEN cycle with remaining=1 -> EW_YELLOW entered on schedule; the next EW_GREEN loads 10.
REQ-034 rst_n asserted in EW_YELLOW with pending[0] set -> outputs immediately at reset values; the following NS_GREEN lasts 60.
REQ-035 With EMERGENCY_PREEMPT_EN, emerg_req=1, emerg_dir=0 during EW_GREEN -> EW_YELLOW next cycle, then AR_EW, then NS_GREEN holds while the request is high.
